// File: rtl/alu_bist.sv
// alu_bist: LFSR-driven built-in self-test initiator for the 4-bit ALU.
// Define ALU_BIST_MISR_EN to compact every sampled result into an 8-bit MISR signature.
module alu_bist #(
   parameter int         NUM_VECTORS = 16,
   parameter logic [7:0] SEED        = 8'hA2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [3:0]  operand_a,
   output logic [3:0]  operand_b,
   output logic [2:0]  opcode,
   input  logic [7:0]  result,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic [7:0]  fail_count,
   output logic [18:0] fail_vec,
   output logic [7:0]  signature
);
   typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;
   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;
   localparam logic [7:0] LAST_VEC = 8'(NUM_VECTORS - 1);
   state_t      state_q, state_d;
   logic [7:0]  lfsr_q, lfsr_d, lfsr_nx, vcnt_q, vcnt_d, fc_q, fc_d, expected;
   logic [2:0]  op_q, op_d;
   logic [18:0] fv_q, fv_d;
   logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d, go, mismatch;
   assign go        = start && (state_q == IDLE || state_q == DONE);
   assign mismatch  = (state_q == SAMPLE) && (result != expected);
   assign lfsr_nx   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
   assign operand_a = lfsr_q[3:0];
   assign operand_b = lfsr_q[7:4];
   assign opcode     = op_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign pass       = pass_q;
   assign fail_count = fc_q;
   assign fail_vec   = fv_q;
   always_comb begin
      expected = 8'h00;
      case (op_q)
         3'd0:    expected = {4'h0, operand_a} + {4'h0, operand_b};
         3'd1:    expected = {4'h0, operand_a} - {4'h0, operand_b};
         3'd2:    expected = {4'h0, operand_a & operand_b};
         3'd3:    expected = {4'h0, operand_a | operand_b};
         3'd4:    expected = {4'h0, operand_a ^ operand_b};
         3'd5:    expected = {4'h0, operand_a} * {4'h0, operand_b};
         3'd6:    expected = {4'h0, ~operand_a};
         default: expected = {4'h0, ~(operand_a ^ operand_b)};
      endcase
   end
   // The LFSR doubles as the operand register, so it is not advanced after the
   // final vector and the operands hold their last driven values in DONE.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      vcnt_d  = vcnt_q;
      op_d    = op_q;
      fc_d    = fc_q;
      fv_d    = fv_q;
      busy_d  = busy_q;
      done_d  = done_q;
      pass_d  = pass_q;
      case (state_q)
         DRIVE: state_d = SAMPLE;
         SAMPLE: begin
            state_d = DRIVE;
            op_d    = op_q + 3'd1;
            if (mismatch) begin
               fc_d = (fc_q == 8'hFF) ? fc_q : fc_q + 8'd1;
               fv_d = (fc_q == 8'h00) ? {op_q, operand_a, operand_b, result} : fv_q;
            end
            if (op_q == 3'd7 && vcnt_q == LAST_VEC) begin
               state_d = DONE;
               op_d    = op_q;
               busy_d  = 1'b0;
            end else if (op_q == 3'd7) begin
               lfsr_d = lfsr_nx;
               vcnt_d = vcnt_q + 8'd1;
            end
         end
         default: begin
            if (go) begin
               state_d = DRIVE;
               lfsr_d  = SEED_EFF;
               vcnt_d  = 8'h00;
               op_d    = 3'd0;
               fc_d    = 8'h00;
               fv_d    = 19'h0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
            end else if (state_q == DONE) begin
               done_d = 1'b1;
               pass_d = (fc_q == 8'h00);
            end
         end
      endcase
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= 8'h00;
         vcnt_q  <= 8'h00;
         op_q    <= 3'd0;
         fc_q    <= 8'h00;
         fv_q    <= 19'h0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         vcnt_q  <= vcnt_d;
         op_q    <= op_d;
         fc_q    <= fc_d;
         fv_q    <= fv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end
`ifdef ALU_BIST_MISR_EN
   logic [7:0] sig_q, sig_d;
   always_comb sig_d = go ? 8'h00 :
                       (state_q == SAMPLE) ? ({sig_q[6:0], sig_q[7] ^ sig_q[5] ^ sig_q[4] ^ sig_q[3]} ^ result) :
                       sig_q;
   always_ff @(posedge clk) sig_q <= rst ? 8'h00 : sig_d;
   assign signature = sig_q;
`else
   assign signature = 8'h00;
`endif
endmodule

// File: doc/alu_bist.md
# alu_bist

Self-checking stimulus engine for the 4-bit `alu`: drives `operand_a`/`operand_b`/`opcode` into the ALU and samples the 8-bit `result`. It generates operand pairs from an LFSR and applies all eight opcodes to each pair. Each sampled result is compared against an internal golden model, and the block reports pass/fail, a saturating mismatch count, the first failing vector and, optionally, a MISR signature. It sits beside the ALU as its built-in self-test initiator.

## Interface
- `NUM_VECTORS`, default 16: operand pairs per run (1..255); each pair is checked under all 8 opcodes.
- `SEED`, default 8'hA2: LFSR start value; 8'h00 is replaced by 8'h01.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: start a run. Sampled only in IDLE or DONE.
- `operand_a` out 4: to ALU; reset 0.
- `operand_b` out 4: to ALU; reset 0.
- `opcode` out 3: to ALU; reset 0.
- `result` in 8: from ALU (combinational path).
- `busy` out 1: run in progress; reset 0.
- `done` out 1: run complete; reset 0. Held until the next `start` or `rst`.
- `pass` out 1: valid when `done`=1; reset 0.
- `fail_count` out 8: mismatches, saturating at 8'hFF; reset 0.
- `fail_vec` out 19: first mismatch as {opcode, a, b, result}; reset 0.
- `signature` out 8: MISR value; reset 0.

## Operation
- Operand source: 8-bit LFSR.
  - `a` = lfsr[3:0], `b` = lfsr[7:4].
  - Advance rule: next = {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Advances once per vector, after opcode 111 is checked.
- Golden model. Operands are zero-extended to 8 bits and all results are mod 2^8:
  - 000: a+b
  - 001: a-b (two's complement, e.g. 2-10 = 8'hF8)
  - 010: a&b
  - 011: a|b
  - 100: a^b
  - 101: a*b
  - 110: {4'h0, ~a}
  - 111: {4'h0, ~(a^b)}
- FSM states: IDLE, DRIVE, SAMPLE, DONE.
  - IDLE/DONE with `start`=1 goes to DRIVE. On that transition: clear `fail_count`, `fail_vec`, `signature`, `done`, `pass`; load lfsr=SEED; set opcode=000.
  - DRIVE goes to SAMPLE. Operands and opcode are already registered at this point, so the ALU settles for one full cycle.
  - SAMPLE compares `result` against the model:
    - On mismatch, `fail_count` increments (saturating).
    - On the first mismatch of the run, `fail_vec` is captured.
    - SAMPLE then goes to DRIVE with opcode+1. After opcode 111, opcode wraps to 000 and the LFSR advances; if this was the last vector, the FSM goes to DONE.
  - DONE: `busy`=0, `done`=1, `pass` = (`fail_count`==0).
- `start` while busy (DRIVE/SAMPLE) is ignored.
- `rst` at any time, including mid-run: next edge enters IDLE with every output at its reset value.
- Operand and opcode outputs hold their last driven values in DONE.

## Timing
- `busy` rises on the edge that samples `start`.
- Each check takes 2 cycles; a run is 16·NUM_VECTORS cycles.
- `done` is asserted 16·NUM_VECTORS+1 edges after the `start` sampling edge.
- `result` is sampled at the end of SAMPLE, one full cycle after the operands change.
- `fail_count`, `fail_vec` and `signature` update on the SAMPLE edge and are stable in DONE.

## Configuration
- `ALU_BIST_MISR_EN` defined:
  - On every SAMPLE edge: signature <= {sig[6:0], sig[7]^sig[5]^sig[4]^sig[3]} ^ result.
  - The signature is cleared on start.
- `ALU_BIST_MISR_EN` undefined: no MISR logic; `signature` is tied to 8'h00.

## Test plan
- Correct ALU, NUM_VECTORS=1, SEED=8'hA2 (a=2, b=A) -> sampled results are 0C, F8, 02, 0A, 08, 14, 0D, 07 in that order. `done` is asserted 17 edges after start, with `pass`=1 and `fail_count`=0.
- ALU forced to return 8'h00 on opcode 000, NUM_VECTORS=1 -> `fail_count`=1, `pass`=0, `fail_vec`={3'b000, 4'h2, 4'hA, 8'h00}.
- `start` pulsed again mid-run, then `rst` asserted at cycle 9 -> the second start has no effect; after reset every output is 0 and the FSM is in IDLE. A fresh start then completes normally.
- ALU stuck at 8'h5A, NUM_VECTORS=64 -> ≥255 mismatches; `fail_count` holds 8'hFF with no wrap, and `fail_vec` holds the first mismatch.
- With `ALU_BIST_MISR_EN`, two identical runs give an identical nonzero signature; a single-bit fault in one result changes it. Without the macro, `signature`=8'h00 throughout.
- SEED=8'h00 -> first vector is a=1, b=0, and the run completes with `pass`=1.
